// File: rtl/synth_pkg.sv
// Shared definitions for the synthesizer stream path: FSM state encoding,
// the SPI stream-port address and the unsigned audio midscale value.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_PLAY     = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_t;

    localparam logic [7:0] STREAM_ADDR = 8'h06;
    localparam logic [7:0] MIDSCALE    = 8'h80;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous byte FIFO with flush, registered occupancy and its next value.
// The caller guarantees no push when full without a pop, and no pop when empty.
module sample_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign dout       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;
    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == {CW{1'b0}});

    // Occupancy after this cycle's flush/push/pop.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = {CW{1'b0}};
        end else begin
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; flush rewinds both pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/stream_sample_scheduler.sv
// Streams SPI-written sample bytes to the output at a programmable rate with
// prime/underrun handling. Build option STREAM_HOLD_LAST_EN holds the last sample on underrun.
module stream_sample_scheduler
    import synth_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int PRIME_LEVEL = 4,
    parameter int RATE_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    input  logic [RATE_W-1:0]        rate_div,
    input  logic                     clr_flags,
    output logic [7:0]               sample_out,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     playing,
    output logic                     flag_overflow,
    output logic                     flag_underrun
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t             state_q;
    logic [RATE_W-1:0]  cnt_q;
    logic [RATE_W-1:0]  cnt_d;
    logic [7:0]         sample_q;
    logic               strobe_q;
    logic               ovf_flag_q;
    logic               und_flag_q;

    logic               run_s;
    logic               tick_s;
    logic               pop_s;
    logic               push_s;
    logic               ovf_s;
    logic               und_s;
    logic               primed_s;
    logic [7:0]         fifo_dout_s;
    logic [CW-1:0]      fifo_count_s;
    logic [CW-1:0]      fifo_count_next_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (!enable),
        .push       (push_s),
        .pop        (pop_s),
        .din        (wr_data),
        .dout       (fifo_dout_s),
        .count      (fifo_count_s),
        .count_next (fifo_count_next_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Tick generation and FIFO handshake decisions for this cycle.
    always_comb begin
        run_s    = (state_q == ST_PLAY) || (state_q == ST_UNDERRUN);
        tick_s   = enable && run_s && (cnt_q >= rate_div);
        pop_s    = tick_s && (state_q == ST_PLAY) && !fifo_empty_s;
        und_s    = tick_s && (state_q == ST_PLAY) && fifo_empty_s;
        push_s   = enable && wr_valid && (!fifo_full_s || pop_s);
        ovf_s    = enable && wr_valid && fifo_full_s && !pop_s;
        primed_s = (fifo_count_next_s >= CW'(PRIME_LEVEL));
        cnt_d    = {RATE_W{1'b0}};
        if (!enable || !run_s) begin
            cnt_d = {RATE_W{1'b0}};
        end else if (tick_s) begin
            cnt_d = {RATE_W{1'b0}};
        end else begin
            cnt_d = cnt_q + RATE_W'(1);
        end
    end

    // Playback FSM with registered sample, strobe and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {RATE_W{1'b0}};
            sample_q   <= MIDSCALE;
            strobe_q   <= 1'b0;
            ovf_flag_q <= 1'b0;
            und_flag_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            strobe_q <= 1'b0;
            // A set condition beats a coincident clear.
            if (ovf_s) begin
                ovf_flag_q <= 1'b1;
            end else if (clr_flags) begin
                ovf_flag_q <= 1'b0;
            end
            if (und_s) begin
                und_flag_q <= 1'b1;
            end else if (clr_flags) begin
                und_flag_q <= 1'b0;
            end
            if (!enable) begin
                state_q  <= ST_IDLE;
                sample_q <= MIDSCALE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q  <= ST_PRIME;
                        sample_q <= MIDSCALE;
                    end
                    ST_PRIME: begin
                        if (primed_s) begin
                            state_q <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (pop_s) begin
                            sample_q <= fifo_dout_s;
                            strobe_q <= 1'b1;
                        end else if (und_s) begin
                            state_q <= ST_UNDERRUN;
`ifndef STREAM_HOLD_LAST_EN
                            sample_q <= MIDSCALE;
`endif
                        end
                    end
                    ST_UNDERRUN: begin
                        if (primed_s) begin
                            state_q <= ST_PLAY;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        sample_q <= MIDSCALE;
                    end
                endcase
            end
        end
    end

    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign fill_level    = fifo_count_s;
    assign playing       = (state_q == ST_PLAY);
    assign flag_overflow = ovf_flag_q;
    assign flag_underrun = und_flag_q;

endmodule

// File: doc/stream_sample_scheduler.md
Name: stream_sample_scheduler

Overview:
Sequences sample delivery to the oscillator output path when STREAM_MODE is set in the control register. SPI writes to the stream port (address 0x06) push bytes into a small FIFO. A programmable rate divider pops them at a fixed sample rate. A priming/underrun state machine keeps the output glitch-free. Sits between spi_rx_registers and the volume/output stage.

Parameters:
- DEPTH, 8, FIFO depth in samples; power of two, minimum 4
- PRIME_LEVEL, 4, fill level needed before playback starts or resumes; range 1..DEPTH
- RATE_W, 16, width of the rate divider

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  reg_control[0] & reg_control[1] (OSC_EN and STREAM_MODE)
- wr_valid  in  1  one-cycle strobe: SPI data byte written to address 0x06
- wr_data  in  8  sample byte, unsigned
- rate_div  in  RATE_W  sample period minus 1, in clk cycles
- clr_flags  in  1  one-cycle strobe: clears the sticky flags
- sample_out  out  8  current output sample, unsigned, midscale 0x80
- sample_strobe  out  1  one-cycle pulse when sample_out takes a newly popped sample
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy
- playing  out  1  high while in PLAY
- flag_overflow  out  1  sticky: a push was dropped because the FIFO was full
- flag_underrun  out  1  sticky: a tick arrived while the FIFO was empty in PLAY

Behaviour:
- Reset, rst_n low at a posedge:
  - sample_out=0x80; all other outputs 0
  - FIFO pointers and tick counter cleared; state IDLE
- Tick generator:
  - Counter runs only in PLAY and UNDERRUN; held at 0 otherwise.
  - tick=1 when counter >= rate_div; the counter then returns to 0, otherwise it increments.
  - rate_div=0 gives a tick every cycle.
  - Lowering rate_div below the current count fires a tick on the next cycle.
- FIFO:
  - Push when wr_valid and (not full, or a pop occurs in the same cycle).
  - wr_valid while full with no same-cycle pop sets flag_overflow; the byte is dropped and FIFO contents are unchanged.
  - Pushes are accepted in every state while enable=1.
  - There is no write-through: a same-cycle push into an empty FIFO is not poppable that cycle.
- State machine, 2 bits:
  - IDLE: FIFO flushed; sample_out=0x80. When enable=1, go to PRIME.
  - PRIME: collect samples. When fill_level >= PRIME_LEVEL (registered value, after this cycle's push), go to PLAY next cycle with the counter at 0.
  - PLAY: on tick with FIFO not empty, pop, drive sample_out with the popped data and pulse sample_strobe (both registered, 1 cycle after tick). On tick with FIFO empty, set flag_underrun and go to UNDERRUN; sample_out follows the Optional Feature rule.
  - UNDERRUN: ticks continue, with no pops and no strobes. When fill_level >= PRIME_LEVEL, return to PLAY; the next tick pops.
- enable falling in any state:
  - Next cycle: state IDLE, FIFO flushed, sample_out=0x80, counter 0.
  - Flags retained.
- clr_flags:
  - Clears both flags.
  - If a set condition occurs in the same cycle, the set wins.
- playing = (state==PLAY). fill_level is registered.
- Pointers are log2(DEPTH) bits and wrap naturally; full/empty are decided from the occupancy counter.

Optional Feature:
Macro STREAM_HOLD_LAST_EN.
- Defined: on underrun, sample_out holds the last popped sample.
- Undefined: on underrun, sample_out is forced to 0x80 on the cycle after the underrun tick.
- Either way, sample_strobe stays low during UNDERRUN.

Decomposition:
- Shared package synth_pkg:
  - state localparams ST_IDLE=0, ST_PRIME=1, ST_PLAY=2, ST_UNDERRUN=3
  - STREAM_ADDR=8'h06, MIDSCALE=8'h80
- One sub-module: sample_fifo, a synchronous FIFO with push/pop/flush, occupancy count and full/empty.
- The tick counter and FSM stay in the top level.

Test Plan:
- Reset: rst_n low 2 cycles, with wr_valid held high during reset -> sample_out=0x80, fill_level=0, flags 0, state IDLE.
- Prime and play: enable=1, rate_div=3, push 0x10,0x20,0x30,0x40 -> PLAY after the 4th push; then 0x10,0x20,0x30,0x40 appear at 4-cycle spacing, each with a single sample_strobe.
- Underrun: continue with no pushes -> 5th tick sets flag_underrun, playing=0, sample_out=0x40 (macro defined) or 0x80 (undefined). Push 4 bytes -> PLAY resumes.
- Overflow: rate_div=0xFFFF, push 9 bytes -> fill_level=8, flag_overflow=1, 9th byte never output. Then push exactly on a tick cycle while full -> accepted, no new overflow.
- Flags and disable: clr_flags coincident with an overflow -> flag stays 1. Drop enable mid-PLAY -> next cycle IDLE, fill_level=0, sample_out=0x80, flags retained.
- Rate edges: rate_div=0 -> one pop per cycle. Change rate_div 10->2 while counter=5 -> tick on the next cycle.
